// File: rtl/la_i2c_host_ctrl.sv
// Byte-level I2C host sequencer: turns START/STOP/WRITE/READ commands into
// open-drain SCL/SDA waveforms, with clock stretching and a runtime bit rate.
module la_i2c_host_ctrl #(
   parameter int DIVW = 16
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic [DIVW-1:0] clkdiv,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_op,
   input  logic [7:0]      cmd_data,
   input  logic            cmd_nack,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [7:0]      rsp_data,
   output logic            rsp_nack,
   output logic            rsp_err,
   output logic            busy,
   input  logic            i2c_scl_in,
   input  logic            i2c_sda_in,
   output logic            i2c_scl_out,
   output logic            i2c_sda_out,
   output logic            i2c_scl_oe,
   output logic            i2c_sda_oe
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_BIT, S_RESP} state_t;

   localparam logic [1:0] OP_START = 2'd0;
   localparam logic [1:0] OP_STOP  = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;
   localparam logic [1:0] OP_READ  = 2'd3;

   state_t          r_state, w_state_nxt;
   logic [1:0]      r_scl_sync, r_sda_sync, r_rel_dly;
   logic [1:0]      r_op, r_phase;
   logic [7:0]      r_shift, r_rsp_data;
   logic [3:0]      r_bit;
   logic [DIVW-1:0] r_div, r_cnt;
   logic            r_cmd_nack, r_busy, r_sda_last, r_rsp_nack, r_rsp_err;
   logic            w_scl, w_sda, w_accept, w_active, w_stretch, w_phase_end, w_last;
   logic            w_scl_oe, w_sda_oe;

   assign w_scl       = r_scl_sync[1];
   assign w_sda       = r_sda_sync[1];
   assign rsp_valid   = (r_state == S_RESP);
   assign cmd_ready   = (r_state == S_IDLE) & ~rsp_valid;
   assign w_accept    = cmd_valid & cmd_ready;
   assign w_active    = (r_state == S_START) | (r_state == S_STOP) | (r_state == S_BIT);
   // A low SCL only counts as stretching once our own release has had time to
   // cross the synchronizer, so unstretched phases keep their exact length.
   assign w_stretch   = w_active & ~w_scl_oe & r_rel_dly[1] & ~w_scl;
   assign w_phase_end = w_active & ~w_stretch & (r_cnt == r_div);
   assign w_last      = w_phase_end & (r_phase == 2'd3) &
                        ((r_state != S_BIT) | (r_bit == 4'd8));

   assign rsp_data    = r_rsp_data;
   assign rsp_nack    = r_rsp_nack;
   assign rsp_err     = r_rsp_err;
   assign busy        = r_busy;
   assign i2c_scl_out = 1'b0;
   assign i2c_sda_out = 1'b0;
   assign i2c_scl_oe  = w_scl_oe;
   assign i2c_sda_oe  = w_sda_oe;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // NOTE: every always_comb output is given a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:
            if (w_accept) begin
               case (cmd_op)
                  OP_START: w_state_nxt = S_START;
                  OP_STOP:  w_state_nxt = r_busy ? S_STOP : S_RESP;
                  default:  w_state_nxt = r_busy ? S_BIT  : S_RESP;
               endcase
            end
         S_START, S_STOP, S_BIT:
            if (w_last) w_state_nxt = S_RESP;
         S_RESP:
            if (rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Between commands the host parks SCL low while it owns the bus and keeps SDA.
   always_comb begin
      w_scl_oe = r_busy;
      w_sda_oe = r_sda_last;
      case (r_state)
         S_START: begin
            w_scl_oe = (r_phase == 2'd0) | (r_phase == 2'd3);
            w_sda_oe = r_phase[1];
         end
         S_STOP: begin
            w_scl_oe = (r_phase == 2'd0);
            w_sda_oe = ~r_phase[1];
         end
         S_BIT: begin
            w_scl_oe = ~r_phase[1];
            if (r_bit == 4'd8) w_sda_oe = (r_op == OP_READ)  & ~r_cmd_nack;
            else               w_sda_oe = (r_op == OP_WRITE) & ~r_shift[7];
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_scl_sync <= 2'b11;
         r_sda_sync <= 2'b11;
         r_rel_dly  <= 2'b11;
         r_op       <= OP_START;
         r_phase    <= 2'd0;
         r_shift    <= 8'd0;
         r_bit      <= 4'd0;
         r_div      <= '0;
         r_cnt      <= '0;
         r_cmd_nack <= 1'b0;
         r_busy     <= 1'b0;
         r_sda_last <= 1'b0;
         r_rsp_data <= 8'd0;
         r_rsp_nack <= 1'b0;
         r_rsp_err  <= 1'b0;
      end else begin
         r_scl_sync <= {r_scl_sync[0], i2c_scl_in};
         r_sda_sync <= {r_sda_sync[0], i2c_sda_in};
         r_rel_dly  <= {r_rel_dly[0], ~w_scl_oe};
         r_sda_last <= w_sda_oe;
         if (w_accept) begin
            r_op       <= cmd_op;
            r_shift    <= cmd_data;
            r_cmd_nack <= cmd_nack;
            r_div      <= clkdiv;
            r_cnt      <= '0;
            r_bit      <= 4'd0;
            r_phase    <= ((cmd_op == OP_START) & ~r_busy) ? 2'd2 : 2'd0;
            r_rsp_data <= 8'd0;
            r_rsp_nack <= 1'b0;
            r_rsp_err  <= cmd_op[1] & ~r_busy;
            if (cmd_op == OP_START) r_busy <= 1'b1;
         end else if (w_phase_end) begin
            r_cnt   <= '0;
            r_phase <= r_phase + 2'd1;
            if ((r_state == S_BIT) && (r_phase == 2'd2)) begin
               if ((r_op == OP_READ) && !r_bit[3]) r_rsp_data <= {r_rsp_data[6:0], w_sda};
               if ((r_op == OP_WRITE) && r_bit[3])  r_rsp_nack <= w_sda;
            end
            if ((r_state == S_BIT) && (r_phase == 2'd3)) begin
               r_bit   <= r_bit + 4'd1;
               r_shift <= {r_shift[6:0], 1'b0};
            end
            if ((r_state == S_STOP) && (r_phase == 2'd3)) r_busy <= 1'b0;
         end else if (w_active && !w_stretch) begin
            r_cnt <= r_cnt + DIVW'(1);
         end
      end
   end

endmodule

// File: doc/la_i2c_host_ctrl.md
Name: la_i2c_host_ctrl

Overview:
- Byte-level I2C host sequencer that generates all SCL/SDA waveforms for the I2C pad interface (scl/sda in/out/oe).
- Firmware or a UMI register front-end issues START/WRITE/READ/STOP commands over a valid/ready channel.
- Each accepted command returns exactly one response.
- Supports clock stretching and a runtime-programmable bit rate.

Parameters:
- DIVW, 16, width of clock divider field; quarter-bit period = clkdiv+1 clk cycles.

Ports:
- clk  input  1  core clock
- nreset  input  1  active-low async reset
- clkdiv  input  DIVW  quarter-period divider; sampled at command accept
- cmd_valid  input  1  command valid
- cmd_ready  output  1  command ready
- cmd_op  input  2  0=START, 1=STOP, 2=WRITE, 3=READ
- cmd_data  input  8  WRITE byte, sent MSB first
- cmd_nack  input  1  READ: ninth-bit value host drives (0=ACK, 1=NACK)
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response ready
- rsp_data  output  8  READ byte; 0 for other ops
- rsp_nack  output  1  WRITE: sampled device ack bit; else 0
- rsp_err  output  1  WRITE/READ issued while bus idle (no START)
- busy  output  1  bus owned (between START and STOP)
- i2c_scl_in  input  1  SCL pad input
- i2c_sda_in  input  1  SDA pad input
- i2c_scl_out  output  1  tied 0 (open-drain)
- i2c_sda_out  output  1  tied 0 (open-drain)
- i2c_scl_oe  output  1  1 = pull SCL low
- i2c_sda_oe  output  1  1 = pull SDA low

Behaviour:
- Interface: one clock clk; reset nreset is asynchronous, active-low.
- Reset values: both oe=0 (lines released), rsp_valid=0, rsp_data=0, rsp_nack=0, rsp_err=0, busy=0, state IDLE.
- Reset mid-transfer releases SCL/SDA immediately and abandons any pending response.
- Input sync: i2c_scl_in and i2c_sda_in each pass through 2-flop synchronizers; all logic uses the synced copies.
- cmd_ready = (state==IDLE) & ~rsp_valid.
- Accept: cmd_valid & cmd_ready. Capture op, data, cmd_nack, clkdiv at accept.
- Response: rsp_valid asserts the cycle after the last phase ends and holds, with stable fields, until rsp_ready.
- Bit timing: each bit/condition is 4 phases P0..P3. Each phase lasts clkdiv+1 cycles.
- Clock stretching: in any phase where SCL is released, the phase counter holds at 0 while synced SCL reads low.
- States: IDLE, START, STOP, BIT, RESP.
- START:
  - If busy=0, run P2-P3 only: P2 SDA low, SCL high; P3 both low.
  - If busy=1 (repeated start), run all four: P0 SCL low, SDA released; P1 SCL released (stretch), SDA released; P2 SDA low; P3 SCL low.
  - Sets busy=1.
- WRITE (busy=1): 9 bits via BIT.
  - Bits 0-7: SDA driven from cmd_data, MSB first; SDA changes only at P0 entry while SCL low.
  - P0-P1: SCL low. P2-P3: SCL released.
  - Bit 8: SDA released; synced SDA sampled at the end of P2 -> rsp_nack.
- READ (busy=1):
  - Bits 0-7: SDA released; sampled at the end of P2, shifted into rsp_data MSB first.
  - Bit 8: SDA = cmd_nack.
- STOP:
  - If busy=1: P0 SCL low, SDA low; P1 SCL released (stretch), SDA low; P2-P3 SDA released. Clears busy.
  - If busy=0: no bus activity; response in the next cycle.
- WRITE/READ with busy=0: no bus activity; response next cycle with rsp_err=1.
- Idle hold: between commands with busy=1, SCL stays low and SDA holds its last level.
- Latency (N=clkdiv):
  - WRITE/READ: 36*(N+1) cycles accept-to-rsp_valid, plus stretch cycles.
  - START from idle: 2*(N+1).
  - STOP / repeated START: 4*(N+1).

Test Plan:
- Reset with lines idle -> both oe=0, cmd_ready=1, busy=0. Assert nreset mid-WRITE -> oe drop to 0 asynchronously, no rsp.
- clkdiv=3: START, WRITE 0xA5 with device ack 0, STOP.
  - SDA bits 1,0,1,0,0,1,0,1 each stable while SCL high; each SCL high = 8 cycles.
  - Responses: rsp_nack=0, rsp_err=0; rsp_valid 144 cycles after WRITE accept; busy 1->0 after STOP.
- READ with device driving 0x3C, cmd_nack=1 -> rsp_data=0x3C; host releases SDA on the 9th bit.
- Device holds SCL low 20 cycles in P2 of bit 3 -> phase extended exactly until synced SCL high; data unaffected; WRITE latency grows accordingly.
- WRITE with busy=0 -> rsp_err=1, oe never asserted. STOP with busy=0 -> rsp, no activity.
- Hold rsp_ready=0 for 50 cycles -> rsp fields stable, cmd_ready=0. Issue START, START -> second START produces a repeated-start waveform.
